// File: rtl/jump_unit.sv
// jump_unit: next-PC select (pc, offset, jump_type, branch_taken -> jump_addr, link, taken, link_addr) plus registered ret_addr_q/taken_q
module jump_unit #(
  parameter int ADDR_W  = 21,
  parameter int PC_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] offset,
  input  logic [1:0]        jump_type,
  input  logic              branch_taken,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              link,
  output logic              taken,
  output logic [ADDR_W-1:0] link_addr,
  output logic [ADDR_W-1:0] ret_addr_q,
  output logic              taken_q
);
  logic [ADDR_W-1:0] seq, tgt;
  always_comb begin
    seq       = pc + ADDR_W'(PC_STEP);
    tgt       = pc + offset;
    taken     = jump_type[1] | (jump_type[0] & branch_taken);
    link      = &jump_type;
    jump_addr = taken ? tgt : seq;
    link_addr = seq;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ret_addr_q <= '0;
      taken_q    <= 1'b0;
    end else begin
      taken_q <= taken;
      if (link) ret_addr_q <= seq;
    end
  end
endmodule

// File: tb/tb_jump_unit.sv
// tb_jump_unit: scoreboard-driven directed and random checks of jump_unit
module tb_jump_unit;
  localparam int W = 21;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] pc = '0, offset = '0;
  logic [1:0] jump_type = 2'b00;
  logic branch_taken = 1'b0;
  logic [W-1:0] jump_addr, link_addr, ret_addr_q;
  logic link, taken, taken_q;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] ja;
    logic         lk;
    logic         tk;
    logic [W-1:0] la;
  } comb_t;
  typedef struct packed {
    logic [W-1:0] ret;
    logic         tq;
  } reg_t;
  comb_t comb_q[$];
  reg_t  reg_q[$];
  logic [W-1:0] ret_m = '0;

  jump_unit #(.ADDR_W(W), .PC_STEP(1)) dut (
    .clk(clk), .rst(rst), .pc(pc), .offset(offset), .jump_type(jump_type),
    .branch_taken(branch_taken), .jump_addr(jump_addr), .link(link), .taken(taken),
    .link_addr(link_addr), .ret_addr_q(ret_addr_q), .taken_q(taken_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [W-1:0] p, input logic [W-1:0] o,
                      input logic [1:0] jt, input logic bt);
    comb_t c;
    reg_t  g;
    logic  t;
    logic [W-1:0] nxt;
    @(negedge clk);
    rst = r; pc = p; offset = o; jump_type = jt; branch_taken = bt;
    case (jt)
      2'b00:   t = 1'b0;
      2'b01:   t = bt;
      default: t = 1'b1;
    endcase
    nxt = p + W'(1);
    c.ja = t ? W'(p + o) : nxt;
    c.lk = (jt == 2'b11);
    c.tk = t;
    c.la = nxt;
    comb_q.push_back(c);
    #1;
    c = comb_q.pop_front();
    check("jump_addr", 32'(jump_addr), 32'(c.ja));
    check("link", 32'(link), 32'(c.lk));
    check("taken", 32'(taken), 32'(c.tk));
    check("link_addr", 32'(link_addr), 32'(c.la));
    @(posedge clk);
    if (r) ret_m = '0;
    else if (c.lk) ret_m = nxt;
    g.ret = ret_m;
    g.tq  = r ? 1'b0 : t;
    reg_q.push_back(g);
    #1;
    g = reg_q.pop_front();
    check("ret_addr_q", 32'(ret_addr_q), 32'(g.ret));
    check("taken_q", 32'(taken_q), 32'(g.tq));
  endtask

  initial begin
    step(1'b1, W'(5), W'(7), 2'b00, 1'b0);
    check("reset_ret", 32'(ret_addr_q), 32'd0);
    check("reset_tq", 32'(taken_q), 32'd0);
    step(1'b0, W'(100), W'(50), 2'b00, 1'b0);
    check("none_ja", 32'(jump_addr), 32'd101);
    step(1'b0, W'(100), W'(50), 2'b01, 1'b0);
    check("cond_nt_ja", 32'(jump_addr), 32'd101);
    step(1'b0, W'(100), W'(50), 2'b01, 1'b1);
    check("cond_t_ja", 32'(jump_addr), 32'd150);
    step(1'b0, W'(100), W'(50), 2'b10, 1'b0);
    check("uncond_ja", 32'(jump_addr), 32'd150);
    step(1'b0, W'(100), W'(50), 2'b11, 1'b0);
    check("jal_ja", 32'(jump_addr), 32'd150);
    check("jal_link", 32'(link), 32'd1);
    check("jal_ret", 32'(ret_addr_q), 32'd101);
    check("jal_tq", 32'(taken_q), 32'd1);
    step(1'b0, W'(300), W'(4), 2'b00, 1'b1);
    check("hold_ret", 32'(ret_addr_q), 32'd101);
    check("hold_tq", 32'(taken_q), 32'd0);
    step(1'b0, W'(10), 21'h1FFFF6, 2'b10, 1'b0);
    check("neg_wrap_ja", 32'(jump_addr), 32'd0);
    step(1'b0, 21'h1FFFFF, W'(3), 2'b00, 1'b0);
    check("seq_wrap_ja", 32'(jump_addr), 32'd0);
    step(1'b0, W'(200), W'(8), 2'b11, 1'b1);
    step(1'b0, W'(400), W'(8), 2'b11, 1'b0);
    check("b2b_ret", 32'(ret_addr_q), 32'd401);
    step(1'b1, W'(100), W'(50), 2'b11, 1'b1);
    check("rst_jal_ret", 32'(ret_addr_q), 32'd0);
    check("rst_jal_tq", 32'(taken_q), 32'd0);
    check("rst_jal_ja", 32'(jump_addr), 32'd150);
    for (int i = 0; i < 40; i++)
      step(($urandom_range(0, 9) == 0), W'($urandom), W'($urandom),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
